// File: rtl/pit_timer_pkg.sv
// Shared constants and types for the programmable interval timer.
// The default counter width lives here so that all users agree on it.
package pit_timer_pkg;

    localparam int PIT_WIDTH = 16;

    typedef logic [PIT_WIDTH-1:0] pit_cnt_t;

endpackage : pit_timer_pkg

// File: rtl/cnt_stage.sv
// One loadable up-counter stage: reload register, wrapping counter and carry-out.
// The count wraps to zero when it equals the reload value and the carry-in is set.
module cnt_stage
    import pit_timer_pkg::*;
#(
    parameter int WIDTH = PIT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             ci_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             co_o
);

    logic [WIDTH-1:0] rld_q, rld_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             co;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        co    = (cnt_q == rld_q) && ci_i;
        rld_d = rld_q;
        cnt_d = cnt_q;
        if (ld_i) begin
            rld_d = din_i;
        end
        if (clr_i) begin
            cnt_d = '0;
        end else if (ci_i) begin
            cnt_d = co ? '0 : cnt_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rld_q <= '0;
            cnt_q <= '0;
        end else begin
            rld_q <= rld_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign co_o  = co;

endmodule : cnt_stage

// File: rtl/pit_timer.sv
// Programmable interval timer: prescaler stage cascaded into a divider stage,
// producing a registered one-cycle tick every (pre_rld+1)*(div_rld+1) cycles.
module pit_timer
    import pit_timer_pkg::*;
#(
    parameter int WIDTH = PIT_WIDTH
) (
    input  logic             clk,
    input  logic             resl,
    input  logic [WIDTH-1:0] din,
    input  logic             prewr,
    input  logic             divwr,
    output logic [WIDTH-1:0] pre_q,
    output logic [WIDTH-1:0] div_q,
    output logic             run,
    output logic             tick
);

    logic wr;
    logic pre_co;
    logic div_co;
    logic run_q, run_d;
    logic tick_q, tick_d;

    assign wr = prewr | divwr;

    // The divider reload only changes on divwr, so run can track din at that write.
    always_comb begin
        run_d  = divwr ? (din != '0) : run_q;
        tick_d = div_co && !wr;
    end

    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            run_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            tick_q <= tick_d;
        end
    end

    cnt_stage #(.WIDTH(WIDTH)) u_pre (
        .clk   (clk),
        .rst_n (resl),
        .ld_i  (prewr),
        .clr_i (wr),
        .din_i (din),
        .ci_i  (run_q),
        .cnt_o (pre_q),
        .co_o  (pre_co)
    );

    cnt_stage #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .rst_n (resl),
        .ld_i  (divwr),
        .clr_i (wr),
        .din_i (din),
        .ci_i  (pre_co),
        .cnt_o (div_q),
        .co_o  (div_co)
    );

    assign run  = run_q;
    assign tick = tick_q;

endmodule : pit_timer

// File: tb/tb_pit_timer.sv
// Self-checking bench for pit_timer against an arithmetic model based on elapsed
// cycles since the last write: counts and tick follow from modulo arithmetic.
module tb_pit_timer;
    import pit_timer_pkg::*;

    logic     clk   = 1'b0;
    logic     resl  = 1'b1;
    logic     prewr = 1'b0;
    logic     divwr = 1'b0;
    pit_cnt_t din   = '0;
    pit_cnt_t pre_q, div_q;
    logic     run, tick;

    int n_checks = 0;
    int n_pass   = 0;

    longint unsigned m_pre = 0, m_div = 0, m_t = 0;
    bit m_run = 1'b0, m_wrote = 1'b0;

    pit_timer #(.WIDTH(PIT_WIDTH)) dut (
        .clk   (clk),
        .resl  (resl),
        .din   (din),
        .prewr (prewr),
        .divwr (divwr),
        .pre_q (pre_q),
        .div_q (div_q),
        .run   (run),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    function automatic pit_cnt_t exp_pre();
        return pit_cnt_t'(m_t % (m_pre + 1));
    endfunction

    function automatic pit_cnt_t exp_div();
        return pit_cnt_t'((m_t / (m_pre + 1)) % (m_div + 1));
    endfunction

    function automatic logic exp_tick();
        return m_run && !m_wrote && (m_t != 0) && ((m_t % ((m_pre + 1) * (m_div + 1))) == 0);
    endfunction

    function automatic logic [2*PIT_WIDTH+1:0] exp_all();
        return {exp_pre(), exp_div(), m_run, exp_tick()};
    endfunction

    task automatic model_reset();
        m_pre = 0; m_div = 0; m_t = 0; m_run = 1'b0; m_wrote = 1'b0;
    endtask

    // Called at a negative edge; applies strobes across one rising edge and returns at the next negative edge.
    task automatic step(input bit pw, input bit dw, input pit_cnt_t d);
        prewr = pw;
        divwr = dw;
        din   = d;
        @(posedge clk);
        m_wrote = pw | dw;
        if (m_wrote) begin
            if (pw) m_pre = d;
            if (dw) m_div = d;
            m_t   = 0;
            m_run = (m_div != 0);
        end else if (m_run) begin
            m_t++;
        end
        @(negedge clk);
        prewr = 1'b0;
        divwr = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, pit_cnt_t'($urandom));
    endtask

    // Idles until tick is seen; n is the number of edges taken, or -1 if the bound expired.
    task automatic idle_until_tick(input int limit, output int n);
        n = 0;
        do begin
            idle();
            n++;
        end while (tick !== 1'b1 && n < limit);
        if (tick !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        #1 resl = 1'b0;
        #1;
        n_checks++;
        if ({pre_q, div_q, run, tick} !== '0)
            $display("FAIL reset_state: got %h expected 0", {pre_q, div_q, run, tick});
        else n_pass++;
        model_reset();
        @(negedge clk);
        resl = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL reset_idle[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
    endtask

    task automatic test_fast();
        int n;
        step(1'b1, 1'b0, 16'd0);
        step(1'b0, 1'b1, 16'd1);
        n_checks++;
        if (run !== 1'b1) $display("FAIL fast_run: got %b expected 1", run);
        else n_pass++;
        idle_until_tick(10, n);
        n_checks++;
        if (n !== 2) $display("FAIL fast_first_tick: got %0d cycles expected 2", n);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL fast_seq[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
    endtask

    task automatic test_period12();
        int n;
        step(1'b1, 1'b0, 16'd2);
        step(1'b0, 1'b1, 16'd3);
        idle_until_tick(50, n);
        n_checks++;
        if (n !== 12) $display("FAIL p12_first_tick: got %0d cycles expected 12", n);
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL p12_seq[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
    endtask

    task automatic test_mid_prewr();
        int n;
        for (int i = 0; i < 12 && (m_t % 12) != 7; i++) begin
            idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL mid_adv[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
        n_checks++;
        if ({pre_q, div_q} !== {16'd1, 16'd2})
            $display("FAIL mid_before: got pre=%0d div=%0d expected pre=1 div=2", pre_q, div_q);
        else n_pass++;
        step(1'b1, 1'b0, 16'd4);
        n_checks++;
        if ({pre_q, div_q, tick} !== '0)
            $display("FAIL mid_clear: got pre=%0d div=%0d tick=%b expected 0", pre_q, div_q, tick);
        else n_pass++;
        idle_until_tick(100, n);
        n_checks++;
        if (n !== 20) $display("FAIL mid_next_tick: got %0d cycles expected 20", n);
        else n_pass++;
    endtask

    task automatic test_stop();
        int n;
        bit  seen;
        step(1'b0, 1'b1, 16'd0);
        n_checks++;
        if ({pre_q, div_q, run} !== '0)
            $display("FAIL stop_run: got pre=%0d div=%0d run=%b expected 0", pre_q, div_q, run);
        else n_pass++;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            idle();
            if (tick !== 1'b0 || pre_q !== '0 || div_q !== '0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL stop_frozen: got activity=%b expected 0", seen);
        else n_pass++;
        step(1'b0, 1'b1, 16'd1);
        idle_until_tick(50, n);
        n_checks++;
        if (n !== 10) $display("FAIL stop_resume: got %0d cycles expected 10", n);
        else n_pass++;
    endtask

    task automatic test_write_on_expiry();
        int n;
        step(1'b1, 1'b0, 16'd1);
        step(1'b0, 1'b1, 16'd2);
        for (int i = 0; i < 10 && ((m_t + 1) % 6) != 0; i++) idle();
        n_checks++;
        if ({pre_q, div_q} !== {16'd1, 16'd2})
            $display("FAIL exp_before: got pre=%0d div=%0d expected pre=1 div=2", pre_q, div_q);
        else n_pass++;
        step(1'b0, 1'b1, 16'd2);
        n_checks++;
        if ({pre_q, div_q, run, tick} !== {16'd0, 16'd0, 1'b1, 1'b0})
            $display("FAIL exp_write_wins: got %h expected %h", {pre_q, div_q, run, tick}, {16'd0, 16'd0, 1'b1, 1'b0});
        else n_pass++;
        idle_until_tick(20, n);
        n_checks++;
        if (n !== 6) $display("FAIL exp_restart: got %0d cycles expected 6", n);
        else n_pass++;
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      step(1'b1, 1'b0, pit_cnt_t'($urandom_range(0, 4)));
            else if (r == 1) step(1'b0, 1'b1, pit_cnt_t'($urandom_range(0, 4)));
            else if (r == 2) step(1'b1, 1'b1, pit_cnt_t'($urandom_range(0, 3)));
            else             idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL random[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
    endtask

    task automatic test_prescale_max();
        step(1'b1, 1'b0, 16'hFFFF);
        step(1'b0, 1'b1, 16'd1);
        repeat (65535) idle();
        n_checks++;
        if ({pre_q, div_q, run, tick} !== exp_all())
            $display("FAIL max_top: got %h expected %h", {pre_q, div_q, run, tick}, exp_all());
        else n_pass++;
        idle();
        n_checks++;
        if ({pre_q, div_q, run, tick} !== {16'd0, 16'd1, 1'b1, 1'b0})
            $display("FAIL max_wrap: got %h expected %h", {pre_q, div_q, run, tick}, {16'd0, 16'd1, 1'b1, 1'b0});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        repeat (3) idle();
        #1 resl = 1'b0;
        #1;
        n_checks++;
        if ({pre_q, div_q, run, tick} !== '0)
            $display("FAIL reset_mid_async: got %h expected 0", {pre_q, div_q, run, tick});
        else n_pass++;
        model_reset();
        @(negedge clk);
        resl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            idle();
            n_checks++;
            if ({pre_q, div_q, run, tick} !== exp_all())
                $display("FAIL reset_mid_idle[%0d]: got %h expected %h", i, {pre_q, div_q, run, tick}, exp_all());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fast();
        test_period12();
        test_mid_prewr();
        test_stop();
        test_write_on_expiry();
        test_random();
        test_prescale_max();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pit_timer
